// File: rtl/amo_rmw_unit.sv
// RV32A atomic read-modify-write unit: LR/SC and AMO* sequenced over a single word memory port,
// holding the single-hart LR reservation with snoop, SC and timeout clearing.
module amo_rmw_unit #(
  parameter int ID_W        = 4,
  parameter int RSV_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_fn5,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_rs2,
  input  logic [ID_W-1:0] req_id,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  input  logic            snoop_valid,
  input  logic [31:0]     snoop_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_data,
  output logic            resp_err,
  output logic [ID_W-1:0] resp_id,
  output logic            rsv_valid
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [4:0] FN_ADD  = 5'b00000;
  localparam logic [4:0] FN_SWAP = 5'b00001;
  localparam logic [4:0] FN_LR   = 5'b00010;
  localparam logic [4:0] FN_SC   = 5'b00011;
  localparam logic [4:0] FN_XOR  = 5'b00100;
  localparam logic [4:0] FN_OR   = 5'b01000;
  localparam logic [4:0] FN_AND  = 5'b01100;
  localparam logic [4:0] FN_MIN  = 5'b10000;
  localparam logic [4:0] FN_MAX  = 5'b10100;
  localparam logic [4:0] FN_MINU = 5'b11000;
  localparam logic [4:0] FN_MAXU = 5'b11100;

  localparam int              CNT_W    = $clog2(RSV_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSV_TIMEOUT - 1);

  logic [2:0]       state;
  logic [4:0]       op_fn5;
  logic [29:0]      op_word;
  logic [31:0]      op_rs2;
  logic [29:0]      rsv_addr;
  logic [CNT_W-1:0] rsv_cnt;
  logic [31:0]      amo_result;
  logic             fn_ok, req_err, is_sc, sc_ok;
  logic             snoop_hit, lr_set, amo_wr_hit, sc_clear, rsv_timeout;
  logic             unused_ok;

  assign req_ready     = (state == S_IDLE);
  assign mem_req_valid = (state == S_RD_REQ) || (state == S_WR_REQ);
  assign mem_we        = (state == S_WR_REQ);
  assign mem_addr      = {op_word, 2'b00};
  assign resp_valid    = (state == S_RESP);
  assign unused_ok     = ^snoop_addr[1:0];

  always_comb begin
    fn_ok = 1'b0;
    case (req_fn5)
      FN_ADD, FN_SWAP, FN_LR, FN_SC, FN_XOR, FN_OR, FN_AND,
      FN_MIN, FN_MAX, FN_MINU, FN_MAXU: fn_ok = 1'b1;
      default: fn_ok = 1'b0;
    endcase
  end

  assign req_err     = (req_addr[1:0] != 2'b00) || !fn_ok;
  assign is_sc       = (req_fn5 == FN_SC);
  assign snoop_hit   = rsv_valid && snoop_valid && (snoop_addr[31:2] == rsv_addr);
  assign sc_ok       = rsv_valid && (rsv_addr == req_addr[31:2]) && !snoop_hit;
  assign sc_clear    = req_valid && req_ready && !req_err && is_sc;
  assign lr_set      = (state == S_RD_WAIT) && mem_rvalid && (op_fn5 == FN_LR);
  assign amo_wr_hit  = (state == S_WR_REQ) && mem_req_ready && (op_fn5 != FN_SC) &&
                       rsv_valid && (op_word == rsv_addr);
  assign rsv_timeout = rsv_valid && (rsv_cnt == CNT_LAST);

  // Min/max ties keep the old value: the operand is chosen only on a strict win.
  always_comb begin
    amo_result = mem_rdata;
    case (op_fn5)
      FN_SWAP: amo_result = op_rs2;
      FN_ADD:  amo_result = mem_rdata + op_rs2;
      FN_XOR:  amo_result = mem_rdata ^ op_rs2;
      FN_AND:  amo_result = mem_rdata & op_rs2;
      FN_OR:   amo_result = mem_rdata | op_rs2;
      FN_MIN:  amo_result = ($signed(op_rs2) < $signed(mem_rdata)) ? op_rs2 : mem_rdata;
      FN_MAX:  amo_result = ($signed(op_rs2) > $signed(mem_rdata)) ? op_rs2 : mem_rdata;
      FN_MINU: amo_result = (op_rs2 < mem_rdata) ? op_rs2 : mem_rdata;
      FN_MAXU: amo_result = (op_rs2 > mem_rdata) ? op_rs2 : mem_rdata;
      default: amo_result = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_fn5    <= '0;
      op_word   <= '0;
      op_rs2    <= '0;
      mem_wdata <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      resp_id   <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_fn5   <= req_fn5;
          op_word  <= req_addr[31:2];
          op_rs2   <= req_rs2;
          resp_id  <= req_id;
          resp_err <= 1'b0;
          if (req_err) begin
            resp_err  <= 1'b1;
            resp_data <= '0;
            state     <= S_RESP;
          end else if (is_sc) begin
            if (sc_ok) begin
              mem_wdata <= req_rs2;
              resp_data <= '0;
              state     <= S_WR_REQ;
            end else begin
              resp_data <= 32'd1;
              state     <= S_RESP;
            end
          end else begin
            state <= S_RD_REQ;
          end
        end
        S_RD_REQ:  if (mem_req_ready) state <= S_RD_WAIT;
        S_RD_WAIT: if (mem_rvalid) begin
          resp_data <= mem_rdata;
          if (op_fn5 == FN_LR) begin
            state <= S_RESP;
          end else begin
            mem_wdata <= amo_result;
            state     <= S_WR_REQ;
          end
        end
        S_WR_REQ:  if (mem_req_ready) state <= S_RESP;
        S_RESP:    if (resp_ready) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // LR set has priority: a same-cycle snoop precedes the read data it would invalidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsv_valid <= 1'b0;
      rsv_addr  <= '0;
      rsv_cnt   <= '0;
    end else if (lr_set) begin
      rsv_valid <= 1'b1;
      rsv_addr  <= op_word;
      rsv_cnt   <= '0;
    end else if (sc_clear || snoop_hit || amo_wr_hit || rsv_timeout) begin
      rsv_valid <= 1'b0;
      rsv_cnt   <= '0;
    end else if (rsv_valid) begin
      rsv_cnt <= rsv_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_amo_rmw_unit.sv
// Directed bench for amo_rmw_unit: word memory model, AMO vector table, LR/SC reservation cases,
// error decode, stalled handshakes and asynchronous reset during a pending load.
module tb_amo_rmw_unit;

  localparam int TO = 16;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_fn5 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_rs2 = '0;
  logic [3:0]  req_id = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        snoop_valid = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [3:0]  resp_id;
  logic        rsv_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_arr [0:255];
  int          n_mem = 0;
  logic        stall_en = 1'b0;
  logic        hold_rvalid = 1'b0;

  amo_rmw_unit #(.ID_W(4), .RSV_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fn5(req_fn5),
    .req_addr(req_addr), .req_rs2(req_rs2), .req_id(req_id),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .resp_id(resp_id), .rsv_valid(rsv_valid)
  );

  always #5 clk = ~clk;

  // Zero-wait memory: load data returns the cycle after the request is accepted.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (rst_n && mem_req_valid && mem_req_ready) begin
      n_mem = n_mem + 1;
      if (mem_we) begin
        mem_arr[mem_addr[9:2]] = mem_wdata;
      end else if (!hold_rvalid) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem_arr[mem_addr[9:2]];
      end
    end
    mem_req_ready <= stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [4:0] fn, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [3:0] id, output logic [31:0] data, output logic err,
                       output logic [3:0] rid, output int lat);
    int w;
    data = '0; err = 1'b0; rid = '0; lat = 0;
    req_valid = 1'b1; req_fn5 = fn; req_addr = addr; req_rs2 = rs2; req_id = id;
    w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) begin
      check("resp_valid_timeout", 32'd0, 32'd1);
      return;
    end
    if (stall_en) begin
      w = $urandom_range(0, 3);
      repeat (w) begin @(posedge clk); #1; end
    end
    data = resp_data; err = resp_err; rid = resp_id;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  typedef struct { logic [4:0] fn; logic [31:0] init; logic [31:0] rs2; logic [31:0] st; } vec_t;
  vec_t vecs [10];

  logic [31:0] d;
  logic        e;
  logic [3:0]  r;
  int          lat, n0;

  initial begin
    vecs[0] = '{F_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    vecs[1] = '{F_MIN,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
    vecs[2] = '{F_MINU, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[3] = '{F_MAX,  32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
    vecs[4] = '{F_MAXU, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};
    vecs[5] = '{F_SWAP, 32'h12345678, 32'hCAFEBABE, 32'hCAFEBABE};
    vecs[6] = '{F_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    vecs[7] = '{F_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[8] = '{F_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
    vecs[9] = '{F_ADD,  32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rsv_valid", 32'(rsv_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // AMO table, zero-wait memory: data, store value, tag and latency.
    for (int i = 0; i < 10; i++) begin
      mem_arr[64 + i] = vecs[i].init;
      do_op(vecs[i].fn, 32'h100 + 32'(4 * i), vecs[i].rs2, 4'(i + 3), d, e, r, lat);
      check($sformatf("amo%0d_data", i), d, vecs[i].init);
      check($sformatf("amo%0d_err", i), 32'(e), 32'd0);
      check($sformatf("amo%0d_id", i), 32'(r), 32'(i + 3));
      check($sformatf("amo%0d_store", i), mem_arr[64 + i], vecs[i].st);
      check($sformatf("amo%0d_lat", i), 32'(lat), 32'd4);
    end

    // LR then SC success, then a second SC that must fail without touching memory.
    mem_arr[128] = 32'h00000055;
    do_op(F_LR, 32'h200, 32'h0, 4'd1, d, e, r, lat);
    check("lr_data", d, 32'h55);
    check("lr_lat", 32'(lat), 32'd3);
    check("lr_rsv", 32'(rsv_valid), 32'd1);
    n0 = n_mem;
    do_op(F_SC, 32'h200, 32'hAB, 4'd2, d, e, r, lat);
    check("sc_ok_data", d, 32'd0);
    check("sc_ok_lat", 32'(lat), 32'd2);
    check("sc_ok_store", mem_arr[128], 32'hAB);
    check("sc_ok_memreqs", 32'(n_mem - n0), 32'd1);
    check("sc_ok_rsv", 32'(rsv_valid), 32'd0);
    n0 = n_mem;
    do_op(F_SC, 32'h200, 32'hCD, 4'd3, d, e, r, lat);
    check("sc2_data", d, 32'd1);
    check("sc2_lat", 32'(lat), 32'd1);
    check("sc2_memreqs", 32'(n_mem - n0), 32'd0);
    check("sc2_mem", mem_arr[128], 32'hAB);

    // Snoop to the neighbouring word keeps the reservation; same word clears it.
    do_op(F_LR, 32'h200, 32'h0, 4'd4, d, e, r, lat);
    snoop_valid = 1'b1; snoop_addr = 32'h204;
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    check("snoop_other_rsv", 32'(rsv_valid), 32'd1);
    snoop_valid = 1'b1; snoop_addr = 32'h203;
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    check("snoop_hit_rsv", 32'(rsv_valid), 32'd0);
    n0 = n_mem;
    do_op(F_SC, 32'h200, 32'h77, 4'd5, d, e, r, lat);
    check("snoop_sc_data", d, 32'd1);
    check("snoop_sc_memreqs", 32'(n_mem - n0), 32'd0);

    // Reservation timeout.
    do_op(F_LR, 32'h200, 32'h0, 4'd6, d, e, r, lat);
    check("to_rsv_held", 32'(rsv_valid), 32'd1);
    repeat (TO) @(posedge clk);
    #1;
    check("to_rsv_expired", 32'(rsv_valid), 32'd0);
    do_op(F_SC, 32'h200, 32'h77, 4'd7, d, e, r, lat);
    check("to_sc_data", d, 32'd1);

    // Error decode: no memory traffic and the reservation survives.
    do_op(F_LR, 32'h200, 32'h0, 4'd8, d, e, r, lat);
    n0 = n_mem;
    do_op(F_ADD, 32'h102, 32'h1, 4'd9, d, e, r, lat);
    check("mis_err", 32'(e), 32'd1);
    check("mis_data", d, 32'd0);
    check("mis_id", 32'(r), 32'd9);
    check("mis_lat", 32'(lat), 32'd1);
    do_op(5'b11111, 32'h100, 32'h1, 4'd10, d, e, r, lat);
    check("badfn_err", 32'(e), 32'd1);
    do_op(F_SC, 32'h202, 32'h1, 4'd11, d, e, r, lat);
    check("missc_err", 32'(e), 32'd1);
    check("err_memreqs", 32'(n_mem - n0), 32'd0);
    check("err_rsv_kept", 32'(rsv_valid), 32'd1);
    do_op(F_SC, 32'h200, 32'h99, 4'd12, d, e, r, lat);
    check("err_then_sc_data", d, 32'd0);
    check("err_then_sc_store", mem_arr[128], 32'h99);

    // An AMO to the reserved word clears the reservation at its write.
    do_op(F_LR, 32'h200, 32'h0, 4'd13, d, e, r, lat);
    do_op(F_ADD, 32'h200, 32'h1, 4'd14, d, e, r, lat);
    check("amo_rsv_data", d, 32'h99);
    check("amo_rsv_store", mem_arr[128], 32'h9A);
    check("amo_rsv_clear", 32'(rsv_valid), 32'd0);

    // Random memory and response stalls.
    stall_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_arr[64 + i] = vecs[i].init;
      do_op(vecs[i].fn, 32'h100 + 32'(4 * i), vecs[i].rs2, 4'(i), d, e, r, lat);
      check($sformatf("stall%0d_data", i), d, vecs[i].init);
      check($sformatf("stall%0d_store", i), mem_arr[64 + i], vecs[i].st);
    end
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset while waiting for load data.
    do_op(F_LR, 32'h200, 32'h0, 4'd1, d, e, r, lat);
    check("rstmid_rsv_before", 32'(rsv_valid), 32'd1);
    hold_rvalid = 1'b1;
    req_valid = 1'b1; req_fn5 = F_ADD; req_addr = 32'h100; req_rs2 = 32'h1; req_id = 4'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstmid_rdreq", 32'(mem_req_valid), 32'd1);
    @(posedge clk); #1;
    check("rstmid_rdwait", 32'({mem_req_valid, req_ready, resp_valid}), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    check("rstmid_rsv", 32'(rsv_valid), 32'd0);
    check("rstmid_mem_req", 32'(mem_req_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold_rvalid = 1'b0;
    mem_arr[64] = 32'h10;
    do_op(F_ADD, 32'h100, 32'h5, 4'd3, d, e, r, lat);
    check("post_rst_data", d, 32'h10);
    check("post_rst_store", mem_arr[64], 32'h15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
